// File: rtl/mini16_arb_pkg.sv
// rtl/mini16_arb_pkg.sv - shared arbiter state encoding and index-width helper
package mini16_arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // Width of an index into `reqs` entries; never narrower than one bit.
   function automatic int arb_idx_bits(input int reqs);
      return (reqs <= 1) ? 1 : $clog2(reqs);
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin pick: first set request at or after ptr, wrapping
module rr_priority_pick
   import mini16_arb_pkg::*;
#(
   parameter int REQS     = 8,
   parameter int IDX_BITS = arb_idx_bits(REQS)
) (
   input  logic [REQS-1:0]     req,
   input  logic [IDX_BITS-1:0] ptr,
   output logic                found,
   output logic [IDX_BITS-1:0] idx
);

   int pos;

   // Scan ptr, ptr+1, ... modulo REQS; the first set bit wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = 0; k < REQS; k++) begin
         pos = int'(ptr) + k;
         if (pos >= REQS) begin
            pos = pos - REQS;
         end
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = IDX_BITS'(pos);
         end
      end
   end

endmodule

// File: rtl/vram_write_arbiter.sv
// rtl/vram_write_arbiter.sv - round-robin burst arbiter for the single VRAM write port
module vram_write_arbiter
   import mini16_arb_pkg::*;
#(
   parameter int REQS      = 8,
   parameter int ADDR_BITS = 13,
   parameter int DATA_BITS = 8,
   parameter int MAX_BURST = 4,
   localparam int IDX_BITS = arb_idx_bits(REQS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [REQS-1:0]           req,
   input  logic [REQS*ADDR_BITS-1:0] req_addr,
   input  logic [REQS*DATA_BITS-1:0] req_data,
   output logic [REQS-1:0]           ack,
   output logic                      vram_we,
   output logic [ADDR_BITS-1:0]      vram_addr,
   output logic [DATA_BITS-1:0]      vram_data,
   output logic                      grant_valid,
   output logic [IDX_BITS-1:0]       grant_id
);

   localparam int BEAT_BITS = arb_idx_bits(MAX_BURST);
   localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(MAX_BURST - 1);

   arb_state_e           state_q, state_d;
   logic [IDX_BITS-1:0]  rr_ptr_q, rr_ptr_d;
   logic [IDX_BITS-1:0]  owner_q, owner_d;
   logic [BEAT_BITS-1:0] beat_q, beat_d;
   logic                 vram_we_q, vram_we_d;
   logic [ADDR_BITS-1:0] vram_addr_q, vram_addr_d;
   logic [DATA_BITS-1:0] vram_data_q, vram_data_d;

   logic                 pick_found;
   logic [IDX_BITS-1:0]  pick_idx;
   logic [IDX_BITS-1:0]  next_ptr;

   rr_priority_pick #(
      .REQS     (REQS),
      .IDX_BITS (IDX_BITS)
   ) u_pick (
      .req   (req),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign next_ptr = (int'(owner_q) == REQS - 1) ? '0 : owner_q + 1'b1;

   // Arbitration FSM: pick in IDLE, ack/capture beats in GRANT, rotate on release.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      beat_d      = beat_q;
      vram_we_d   = 1'b0;
      vram_addr_d = vram_addr_q;
      vram_data_d = vram_data_q;
      ack         = '0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               owner_d = pick_idx;
               beat_d  = '0;
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (req[owner_q]) begin
               ack[owner_q] = 1'b1;
               vram_we_d    = 1'b1;
               vram_addr_d  = req_addr[int'(owner_q)*ADDR_BITS +: ADDR_BITS];
               vram_data_d  = req_data[int'(owner_q)*DATA_BITS +: DATA_BITS];
               beat_d       = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  rr_ptr_d = next_ptr;
                  state_d  = ARB_IDLE;
               end
            end else begin
               // Owner withdrew: hand the port on without a write this cycle.
               rr_ptr_d = next_ptr;
               state_d  = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // State and output registers; reset also drops a write captured in the reset cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         beat_q      <= '0;
         vram_we_q   <= 1'b0;
         vram_addr_q <= '0;
         vram_data_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         beat_q      <= beat_d;
         vram_we_q   <= vram_we_d;
         vram_addr_q <= vram_addr_d;
         vram_data_q <= vram_data_d;
      end
   end

   assign vram_we     = vram_we_q;
   assign vram_addr   = vram_addr_q;
   assign vram_data   = vram_data_q;
   assign grant_valid = (state_q == ARB_GRANT);
   assign grant_id    = (state_q == ARB_GRANT) ? owner_q : '0;

endmodule
